// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and EX operand front end: forwarding, PC/imm select, load-use detection.
// Optional ID_EX_PERF_CNT_EN adds load-use bubble and flush event counters.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int OPCODE_W = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ID_VALID,
  output logic                ID_READY,
  input  logic [REG_AW-1:0]   ID_RS1_ADDR,
  input  logic [REG_AW-1:0]   ID_RS2_ADDR,
  input  logic [XLEN-1:0]     ID_RS1_DATA,
  input  logic [XLEN-1:0]     ID_RS2_DATA,
  input  logic [XLEN-1:0]     ID_IMM,
  input  logic [XLEN-1:0]     ID_PC,
  input  logic [OPCODE_W-1:0] ID_ALUOP,
  input  logic                ID_SRC1_SEL,
  input  logic                ID_SRC2_SEL,
  input  logic [REG_AW-1:0]   ID_RD_ADDR,
  input  logic                ID_REG_WRITE,
  input  logic                ID_MEM_READ,
  input  logic                ID_MEM_WRITE,
  input  logic                FLUSH,
  input  logic                EX_STALL,
  input  logic [REG_AW-1:0]   EXMEM_RD_ADDR,
  input  logic                EXMEM_REG_WRITE,
  input  logic [XLEN-1:0]     EXMEM_ALU_RESULT,
  input  logic [REG_AW-1:0]   MEMWB_RD_ADDR,
  input  logic                MEMWB_REG_WRITE,
  input  logic [XLEN-1:0]     MEMWB_WB_DATA,
  output logic [XLEN-1:0]     DATA1,
  output logic [XLEN-1:0]     DATA2,
  output logic [OPCODE_W-1:0] OPCODE,
  output logic [XLEN-1:0]     EX_STORE_DATA,
  output logic [REG_AW-1:0]   EX_RD_ADDR,
  output logic                EX_REG_WRITE,
  output logic                EX_MEM_READ,
  output logic                EX_MEM_WRITE,
  output logic                EX_VALID,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]         PERF_BUBBLES,
  output logic [31:0]         PERF_FLUSHES,
`endif
  output logic                LOAD_USE_STALL
);

  typedef struct packed {
    logic                valid;
    logic [REG_AW-1:0]   rs1_addr;
    logic [REG_AW-1:0]   rs2_addr;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc;
    logic [OPCODE_W-1:0] aluop;
    logic                src1_sel;
    logic                src2_sel;
    logic [REG_AW-1:0]   rd_addr;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } ex_t;

  ex_t ex_q, id_d;
  logic load_use;
  logic [XLEN-1:0] rs1v, rs2v;

  // EX/MEM wins over MEM/WB; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   stored,
    input logic [REG_AW-1:0] em_rd,
    input logic              em_we,
    input logic [XLEN-1:0]   em_val,
    input logic [REG_AW-1:0] mw_rd,
    input logic              mw_we,
    input logic [XLEN-1:0]   mw_val
  );
    if (em_we && em_rd != '0 && em_rd == rs) return em_val;
    if (mw_we && mw_rd != '0 && mw_rd == rs) return mw_val;
    return stored;
  endfunction

  // Control flags are qualified by ID_VALID so an idle slot never writes state.
  always_comb begin
    id_d           = '0;
    id_d.valid     = ID_VALID;
    id_d.rs1_addr  = ID_RS1_ADDR;
    id_d.rs2_addr  = ID_RS2_ADDR;
    id_d.rs1_data  = ID_RS1_DATA;
    id_d.rs2_data  = ID_RS2_DATA;
    id_d.imm       = ID_IMM;
    id_d.pc        = ID_PC;
    id_d.aluop     = ID_ALUOP;
    id_d.src1_sel  = ID_SRC1_SEL;
    id_d.src2_sel  = ID_SRC2_SEL;
    id_d.rd_addr   = ID_RD_ADDR;
    id_d.reg_write = ID_REG_WRITE & ID_VALID;
    id_d.mem_read  = ID_MEM_READ & ID_VALID;
    id_d.mem_write = ID_MEM_WRITE & ID_VALID;
  end

  assign load_use = ex_q.valid & ex_q.mem_read & ID_VALID & (ex_q.rd_addr != '0) &
                    ((ex_q.rd_addr == ID_RS1_ADDR) | (ex_q.rd_addr == ID_RS2_ADDR));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         ex_q <= '0;
    else if (FLUSH)    ex_q <= '0;
    else if (EX_STALL) ex_q <= ex_q;
    else if (load_use) ex_q <= '0;
    else               ex_q <= id_d;
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PERF_BUBBLES <= '0;
      PERF_FLUSHES <= '0;
    end else begin
      if (FLUSH) PERF_FLUSHES <= PERF_FLUSHES + 32'd1;
      if (!FLUSH && !EX_STALL && load_use) PERF_BUBBLES <= PERF_BUBBLES + 32'd1;
    end
  end
`endif

  assign rs1v = fwd(ex_q.rs1_addr, ex_q.rs1_data, EXMEM_RD_ADDR, EXMEM_REG_WRITE,
                    EXMEM_ALU_RESULT, MEMWB_RD_ADDR, MEMWB_REG_WRITE, MEMWB_WB_DATA);
  assign rs2v = fwd(ex_q.rs2_addr, ex_q.rs2_data, EXMEM_RD_ADDR, EXMEM_REG_WRITE,
                    EXMEM_ALU_RESULT, MEMWB_RD_ADDR, MEMWB_REG_WRITE, MEMWB_WB_DATA);

  assign DATA1          = ex_q.src1_sel ? ex_q.pc  : rs1v;
  assign DATA2          = ex_q.src2_sel ? ex_q.imm : rs2v;
  assign EX_STORE_DATA  = rs2v;
  assign OPCODE         = ex_q.aluop;
  assign EX_RD_ADDR     = ex_q.rd_addr;
  assign EX_REG_WRITE   = ex_q.reg_write;
  assign EX_MEM_READ    = ex_q.mem_read;
  assign EX_MEM_WRITE   = ex_q.mem_write;
  assign EX_VALID       = ex_q.valid;
  assign LOAD_USE_STALL = load_use;
  assign ID_READY       = ~EX_STALL & ~load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX state is queued at drive time and popped after each edge.
module tb_id_ex_stage;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic        ID_VALID, ID_READY;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_ALUOP;
  logic [31:0] ID_RS1_DATA, ID_RS2_DATA, ID_IMM, ID_PC;
  logic        ID_SRC1_SEL, ID_SRC2_SEL, ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
  logic        FLUSH, EX_STALL;
  logic [4:0]  EXMEM_RD_ADDR, MEMWB_RD_ADDR;
  logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE;
  logic [31:0] EXMEM_ALU_RESULT, MEMWB_WB_DATA;
  logic [31:0] DATA1, DATA2, EX_STORE_DATA;
  logic [4:0]  OPCODE, EX_RD_ADDR;
  logic        EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, EX_VALID, LOAD_USE_STALL;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] PERF_BUBBLES, PERF_FLUSHES;
`endif

  int checks = 0, errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] d1, d2, sd;
    logic [4:0]  op;
    logic        rw;
  } exp_t;
  exp_t exp_q[$];

  id_ex_stage dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_READY(ID_READY),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA),
    .ID_IMM(ID_IMM), .ID_PC(ID_PC), .ID_ALUOP(ID_ALUOP),
    .ID_SRC1_SEL(ID_SRC1_SEL), .ID_SRC2_SEL(ID_SRC2_SEL),
    .ID_RD_ADDR(ID_RD_ADDR), .ID_REG_WRITE(ID_REG_WRITE),
    .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .FLUSH(FLUSH), .EX_STALL(EX_STALL),
    .EXMEM_RD_ADDR(EXMEM_RD_ADDR), .EXMEM_REG_WRITE(EXMEM_REG_WRITE),
    .EXMEM_ALU_RESULT(EXMEM_ALU_RESULT),
    .MEMWB_RD_ADDR(MEMWB_RD_ADDR), .MEMWB_REG_WRITE(MEMWB_REG_WRITE),
    .MEMWB_WB_DATA(MEMWB_WB_DATA),
    .DATA1(DATA1), .DATA2(DATA2), .OPCODE(OPCODE), .EX_STORE_DATA(EX_STORE_DATA),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WRITE(EX_REG_WRITE),
    .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE), .EX_VALID(EX_VALID),
`ifdef ID_EX_PERF_CNT_EN
    .PERF_BUBBLES(PERF_BUBBLES), .PERF_FLUSHES(PERF_FLUSHES),
`endif
    .LOAD_USE_STALL(LOAD_USE_STALL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [31:0] d1, d2, sd,
                      input logic [4:0] op, input logic rw);
    exp_t e;
    e.v = v; e.d1 = d1; e.d2 = d2; e.sd = sd; e.op = op; e.rw = rw;
    exp_q.push_back(e);
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge CLK); #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, {31'd0, EX_VALID}, {31'd0, e.v});
    chk({tag, "_data1"}, DATA1, e.d1);
    chk({tag, "_data2"}, DATA2, e.d2);
    chk({tag, "_store"}, EX_STORE_DATA, e.sd);
    chk({tag, "_opcode"}, {27'd0, OPCODE}, {27'd0, e.op});
    chk({tag, "_regwr"}, {31'd0, EX_REG_WRITE}, {31'd0, e.rw});
  endtask

  task automatic set_id(input logic [4:0] rs1, rs2, input logic [31:0] d1, d2,
                        input logic [4:0] op, rd, input logic rw, mr);
    ID_VALID = 1'b1; ID_RS1_ADDR = rs1; ID_RS2_ADDR = rs2;
    ID_RS1_DATA = d1; ID_RS2_DATA = d2; ID_ALUOP = op; ID_RD_ADDR = rd;
    ID_REG_WRITE = rw; ID_MEM_READ = mr; ID_MEM_WRITE = 1'b0;
    ID_SRC1_SEL = 1'b0; ID_SRC2_SEL = 1'b0; ID_IMM = 32'd0; ID_PC = 32'h400;
  endtask

  task automatic clr_taps();
    EXMEM_RD_ADDR = '0; EXMEM_REG_WRITE = 1'b0; EXMEM_ALU_RESULT = '0;
    MEMWB_RD_ADDR = '0; MEMWB_REG_WRITE = 1'b0; MEMWB_WB_DATA = '0;
  endtask

  initial begin
    set_id(5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ID_VALID = 1'b0; FLUSH = 1'b0; EX_STALL = 1'b0;
    clr_taps();
    #1;
    chk("rst_valid", {31'd0, EX_VALID}, 32'd0);
    chk("rst_data1", DATA1, 32'd0);
    chk("rst_data2", DATA2, 32'd0);
    chk("rst_rd", {27'd0, EX_RD_ADDR}, 32'd0);
    chk("rst_memrd", {31'd0, EX_MEM_READ}, 32'd0);
    @(negedge CLK); RESET = 1'b0; #1;
    chk("rst_ready", {31'd0, ID_READY}, 32'd1);

    // plain register operands
    @(negedge CLK);
    set_id(5'd1, 5'd2, 32'd6, 32'd3, 5'd0, 5'd4, 1'b1, 1'b0);
    push(1'b1, 32'd6, 32'd3, 32'd3, 5'd0, 1'b1);
    tick_check("basic");

    // mid-stream reset, then first edge loads normally
    @(negedge CLK); RESET = 1'b1; #1;
    chk("mrst_valid", {31'd0, EX_VALID}, 32'd0);
    chk("mrst_data1", DATA1, 32'd0);
    chk("mrst_opcode", {27'd0, OPCODE}, 32'd0);
    chk("mrst_regwr", {31'd0, EX_REG_WRITE}, 32'd0);
    RESET = 1'b0;
    set_id(5'd1, 5'd2, 32'd9, 32'd10, 5'd3, 5'd4, 1'b1, 1'b0);
    push(1'b1, 32'd9, 32'd10, 32'd10, 5'd3, 1'b1);
    tick_check("post_rst");

    // forwarding priority on rs1=x5
    @(negedge CLK);
    set_id(5'd5, 5'd2, 32'h11, 32'h22, 5'd2, 5'd8, 1'b1, 1'b0);
    EXMEM_RD_ADDR = 5'd5; EXMEM_REG_WRITE = 1'b1; EXMEM_ALU_RESULT = 32'h100;
    MEMWB_RD_ADDR = 5'd5; MEMWB_REG_WRITE = 1'b1; MEMWB_WB_DATA = 32'h200;
    push(1'b1, 32'h100, 32'h22, 32'h22, 5'd2, 1'b1);
    tick_check("fwd_exmem");
    EXMEM_REG_WRITE = 1'b0; #1;
    chk("fwd_memwb", DATA1, 32'h200);
    MEMWB_REG_WRITE = 1'b0; #1;
    chk("fwd_none", DATA1, 32'h11);

    // x0 is never forwarded
    @(negedge CLK);
    set_id(5'd0, 5'd3, 32'h33, 32'h44, 5'd1, 5'd8, 1'b1, 1'b0);
    EXMEM_RD_ADDR = 5'd0; EXMEM_REG_WRITE = 1'b1;
    MEMWB_RD_ADDR = 5'd0; MEMWB_REG_WRITE = 1'b1;
    push(1'b1, 32'h33, 32'h44, 32'h44, 5'd1, 1'b1);
    tick_check("fwd_x0");

    // EX_STALL holds the stage
    @(negedge CLK);
    EX_STALL = 1'b1;
    set_id(5'd4, 5'd6, 32'h77, 32'h88, 5'd6, 5'd9, 1'b1, 1'b0);
    #1 chk("stall_ready", {31'd0, ID_READY}, 32'd0);
    push(1'b1, 32'h33, 32'h44, 32'h44, 5'd1, 1'b1);
    tick_check("stall_hold");

    // load-use: lw x7 in EX, ID reads x7
    @(negedge CLK);
    EX_STALL = 1'b0; clr_taps();
    set_id(5'd1, 5'd0, 32'h1000, 32'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    ID_SRC2_SEL = 1'b1; ID_IMM = 32'd4;
    push(1'b1, 32'h1000, 32'd4, 32'd0, 5'd0, 1'b1);
    tick_check("lw");
    @(negedge CLK);
    set_id(5'd7, 5'd2, 32'hDEAD, 32'd5, 5'd0, 5'd9, 1'b1, 1'b0);
    #1;
    chk("lu_stall", {31'd0, LOAD_USE_STALL}, 32'd1);
    chk("lu_ready", {31'd0, ID_READY}, 32'd0);
    push(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick_check("lu_bubble");
    @(negedge CLK);
    MEMWB_RD_ADDR = 5'd7; MEMWB_REG_WRITE = 1'b1; MEMWB_WB_DATA = 32'hCAFE;
    #1 chk("lu_release", {31'd0, LOAD_USE_STALL}, 32'd0);
    push(1'b1, 32'hCAFE, 32'd5, 32'd5, 5'd0, 1'b1);
    tick_check("lu_enter");
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_bubbles", PERF_BUBBLES, 32'd1);
`endif

    // FLUSH beats EX_STALL and load-use together
    @(negedge CLK);
    clr_taps();
    set_id(5'd1, 5'd0, 32'h2000, 32'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    ID_SRC2_SEL = 1'b1; ID_IMM = 32'd8;
    push(1'b1, 32'h2000, 32'd8, 32'd0, 5'd0, 1'b1);
    tick_check("lw2");
    @(negedge CLK);
    set_id(5'd2, 5'd7, 32'd1, 32'd2, 5'd4, 5'd10, 1'b1, 1'b0);
    FLUSH = 1'b1; EX_STALL = 1'b1;
    #1 chk("fl_lu", {31'd0, LOAD_USE_STALL}, 32'd1);
    push(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick_check("flush");
    chk("flush_memrd", {31'd0, EX_MEM_READ}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_flushes", PERF_FLUSHES, 32'd1);
    chk("perf_bubbles2", PERF_BUBBLES, 32'd1);
`endif

    // immediate operand vs forwarded store data
    @(negedge CLK);
    FLUSH = 1'b0; EX_STALL = 1'b0;
    set_id(5'd1, 5'd3, 32'h10, 32'h99, 5'd1, 5'd11, 1'b0, 1'b0);
    ID_MEM_WRITE = 1'b1; ID_SRC2_SEL = 1'b1; ID_IMM = 32'hFFFF_FFFC;
    EXMEM_RD_ADDR = 5'd3; EXMEM_REG_WRITE = 1'b1; EXMEM_ALU_RESULT = 32'h55;
    push(1'b1, 32'h10, 32'hFFFF_FFFC, 32'h55, 5'd1, 1'b0);
    tick_check("imm_store");
    chk("store_memwr", {31'd0, EX_MEM_WRITE}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
